// File: rtl/dbus_arbiter_pkg.sv
// dbus_arbiter_pkg: shared types and size encodings for the peripheral data bus arbiter.
package dbus_arbiter_pkg;

    localparam int DBUS_AW = 64;
    localparam int DBUS_DW = 64;

    // Access size encodings, identical to mem_store_type/mem_load_type
    localparam logic [1:0] SIZE_BYTE  = 2'd1;
    localparam logic [1:0] SIZE_WORD  = 2'd2;
    localparam logic [1:0] SIZE_DWORD = 2'd3;

    typedef enum logic [1:0] {
        DBUS_IDLE,
        DBUS_BUS,
        DBUS_RESP
    } dbus_state_t;

    typedef struct packed {
        logic [DBUS_AW-1:0] addr;
        logic [DBUS_DW-1:0] wdata;
        logic               we;
        logic [1:0]         size;
    } dbus_req_t;

endpackage

// File: rtl/dbus_arbiter_arb.sv
// rr_arb2: combinational two-way round-robin picker; on a tie the port that did not own last wins.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_owner,
    output logic [1:0] gnt,
    output logic       win
);
    assign win = (req == 2'b11) ? ~last_owner : req[1];
    assign gnt = (req == 2'b00) ? 2'b00 : (win ? 2'b10 : 2'b01);
endmodule

// File: rtl/dbus_arbiter.sv
// dbus_arbiter: shares one MMIO data bus between the core (port 0) and debugger/DMA (port 1),
// one outstanding transaction at a time, with a no-ready timeout abort.
module dbus_arbiter
    import dbus_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int AW      = DBUS_AW,
    parameter int DW      = DBUS_DW
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [1:0]    req,
    input  logic [AW-1:0] req_addr0,
    input  logic [AW-1:0] req_addr1,
    input  logic [DW-1:0] req_wdata0,
    input  logic [DW-1:0] req_wdata1,
    input  logic [1:0]    req_we,
    input  logic [1:0]    req_size0,
    input  logic [1:0]    req_size1,
    output logic [1:0]    gnt,
    output logic [1:0]    rvalid,
    output logic [DW-1:0] rdata,
    output logic          rerr,
    output logic          busy,
    output logic          bus_valid,
    output logic [AW-1:0] bus_addr,
    output logic [DW-1:0] bus_wdata,
    output logic          bus_we,
    output logic [1:0]    bus_size,
    input  logic          bus_ready,
    input  logic [DW-1:0] bus_rdata
);
    localparam int TW = $clog2(TIMEOUT + 1);

    dbus_state_t   state;
    dbus_req_t     pl;
    dbus_req_t     cand;
    logic          owner;
    logic          last_owner;
    logic          win;
    logic [1:0]    arb_gnt;
    logic [TW-1:0] timer;

    rr_arb2 u_arb (
        .req       (req),
        .last_owner(last_owner),
        .gnt       (arb_gnt),
        .win       (win)
    );

    assign cand = win ? dbus_req_t'{addr: req_addr1, wdata: req_wdata1, we: req_we[1], size: req_size1}
                      : dbus_req_t'{addr: req_addr0, wdata: req_wdata0, we: req_we[0], size: req_size0};

    assign bus_valid = (state == DBUS_BUS);
    assign busy      = (state != DBUS_IDLE);
    assign rvalid    = (state == DBUS_RESP) ? (owner ? 2'b10 : 2'b01) : 2'b00;
    assign bus_addr  = pl.addr;
    assign bus_wdata = pl.wdata;
    assign bus_we    = pl.we;
    assign bus_size  = pl.size;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= DBUS_IDLE;
            pl         <= '0;
            owner      <= 1'b0;
            last_owner <= 1'b1;
            timer      <= '0;
            gnt        <= 2'b00;
            rdata      <= '0;
            rerr       <= 1'b0;
        end else begin
            gnt <= 2'b00;
            case (state)
                DBUS_IDLE: if (|req) begin
                    pl         <= cand;
                    owner      <= win;
                    last_owner <= win;
                    gnt        <= arb_gnt;
                    timer      <= '0;
                    state      <= DBUS_BUS;
                end
                DBUS_BUS: if (bus_ready) begin
                    rdata <= bus_rdata;
                    rerr  <= 1'b0;
                    state <= DBUS_RESP;
                end else if (timer == TW'(TIMEOUT - 1)) begin
                    rdata <= '0;
                    rerr  <= 1'b1;
                    state <= DBUS_RESP;
                end else begin
                    timer <= timer + 1'b1;
                end
                default: state <= DBUS_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dbus_arbiter.sv
// tb_dbus_arbiter: directed stimulus with a queue scoreboard; a negedge monitor pops the
// expected grant on every gnt pulse and the expected response on every rvalid pulse.
module tb_dbus_arbiter;
    import dbus_arbiter_pkg::*;

    localparam logic [63:0] A0 = 64'h0000_0000_1000_0010;
    localparam logic [63:0] A1 = 64'h0000_0000_2000_0020;
    localparam logic [63:0] K  = 64'h5555_0000_AAAA_0000;
    localparam logic [63:0] E0 = 64'h5555_0000_BAAA_0010;
    localparam logic [63:0] E1 = 64'h5555_0000_8AAA_0020;
    localparam logic [63:0] W1 = 64'hAAAA_5555_0000_FFFF;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  req = '0;
    logic [63:0] req_addr0 = '0, req_addr1 = '0;
    logic [63:0] req_wdata0 = '0, req_wdata1 = '0;
    logic [1:0]  req_we = '0;
    logic [1:0]  req_size0 = '0, req_size1 = '0;
    logic [1:0]  gnt, rvalid;
    logic [63:0] rdata;
    logic        rerr, busy, bus_valid, bus_we;
    logic [63:0] bus_addr, bus_wdata;
    logic [1:0]  bus_size;
    logic        bus_ready;
    logic [63:0] bus_rdata;

    typedef struct {logic port; logic [63:0] addr;} gnt_exp_t;
    typedef struct {logic port; logic [63:0] data; logic err;} rsp_exp_t;
    gnt_exp_t gq[$];
    rsp_exp_t rq[$];

    int          vectors = 0, miscompares = 0;
    int          slave_wait = -1, scnt = 0, vcnt = 0;
    logic [63:0] slave_data = '0;
    logic        slave_xor = 1'b0;

    always #5 clock = ~clock;

    dbus_arbiter #(.TIMEOUT(4)) dut (
        .clock(clock), .reset(reset), .req(req),
        .req_addr0(req_addr0), .req_addr1(req_addr1),
        .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
        .req_we(req_we), .req_size0(req_size0), .req_size1(req_size1),
        .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .rerr(rerr), .busy(busy),
        .bus_valid(bus_valid), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_we(bus_we), .bus_size(bus_size),
        .bus_ready(bus_ready), .bus_rdata(bus_rdata)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (busy && n < 60) begin
            @(negedge clock);
            n++;
        end
        check({name, " returns to idle"}, 64'(n < 60), 64'd1);
        check({name, " grants all seen"}, 64'(gq.size()), 64'd0);
        check({name, " responses all seen"}, 64'(rq.size()), 64'd0);
    endtask

    // Slave: asserts ready on BUS cycle number slave_wait (0-based); -1 never answers
    initial begin
        bus_ready = 1'b0;
        bus_rdata = '0;
        forever begin
            @(negedge clock);
            if (bus_valid) begin
                bus_ready = (scnt == slave_wait);
                bus_rdata = slave_data ^ (slave_xor ? bus_addr : 64'd0);
                scnt++;
            end else begin
                bus_ready = 1'b0;
                scnt = 0;
            end
        end
    end

    initial forever begin
        @(negedge clock);
        if (bus_valid) vcnt++;
    end

    initial begin
        gnt_exp_t ge;
        rsp_exp_t re;
        forever begin
            @(negedge clock);
            if (gnt != 2'b00) begin
                if (gq.size() == 0) check("unexpected gnt", 64'(gnt), 64'd0);
                else begin
                    ge = gq.pop_front();
                    check("gnt port", 64'(gnt), ge.port ? 64'd2 : 64'd1);
                    check("bus_addr at gnt", bus_addr, ge.addr);
                end
            end
            if (rvalid != 2'b00) begin
                if (rq.size() == 0) check("unexpected rvalid", 64'(rvalid), 64'd0);
                else begin
                    re = rq.pop_front();
                    check("rvalid port", 64'(rvalid), re.port ? 64'd2 : 64'd1);
                    check("rdata", rdata, re.data);
                    check("rerr", 64'(rerr), 64'(re.err));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        #2 reset = 1'b1;
        #1;
        check("reset gnt", 64'(gnt), 64'd0);
        check("reset rvalid", 64'(rvalid), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset bus_valid", 64'(bus_valid), 64'd0);
        check("reset rdata", rdata, 64'd0);
        check("reset bus_addr", bus_addr, 64'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        // Core read alone, immediate ready
        req_addr0 = 64'h1000_0008; req_size0 = SIZE_DWORD; req_we = 2'b00;
        slave_wait = 0; slave_xor = 1'b0; slave_data = 64'hDEAD_BEEF_CAFE_F00D;
        gq.push_back('{1'b0, 64'h1000_0008});
        rq.push_back('{1'b0, 64'hDEAD_BEEF_CAFE_F00D, 1'b0});
        req = 2'b01;
        @(negedge clock);
        check("t1 gnt cycle 1", 64'(gnt), 64'd1);
        check("t1 bus_valid cycle 1", 64'(bus_valid), 64'd1);
        check("t1 bus_size", 64'(bus_size), 64'd3);
        req = 2'b00;
        @(negedge clock);
        check("t1 rvalid cycle 2", 64'(rvalid), 64'd1);
        check("t1 bus_valid cycle 2", 64'(bus_valid), 64'd0);
        @(negedge clock);
        check("t1 busy cycle 3", 64'(busy), 64'd0);
        drain("t1");

        // DMA write, request dropped right after gnt
        req_addr1 = A1; req_wdata1 = 64'h1111; req_we = 2'b10; req_size1 = SIZE_WORD;
        slave_wait = 1; slave_data = 64'h77;
        gq.push_back('{1'b1, A1});
        rq.push_back('{1'b1, 64'h77, 1'b0});
        req = 2'b10;
        @(negedge clock);
        req = 2'b00;
        check("t6 bus_we", 64'(bus_we), 64'd1);
        check("t6 bus_wdata", bus_wdata, 64'h1111);
        drain("t6");

        // Both requesting for four transactions: core, dma, core, dma
        req_addr0 = A0; req_addr1 = A1; req_we = 2'b00;
        slave_wait = 0; slave_xor = 1'b1; slave_data = K;
        for (int i = 0; i < 4; i++) begin
            gq.push_back('{i[0], i[0] ? A1 : A0});
            rq.push_back('{i[0], i[0] ? E1 : E0, 1'b0});
        end
        req = 2'b11;
        repeat (11) @(negedge clock);
        req = 2'b00;
        drain("t2");

        // DMA write timeout
        req_addr1 = 64'h3000_0000; req_we = 2'b10;
        slave_wait = -1; slave_xor = 1'b0; slave_data = 64'hFFFF; vcnt = 0;
        gq.push_back('{1'b1, 64'h3000_0000});
        rq.push_back('{1'b1, 64'd0, 1'b1});
        req = 2'b10;
        @(negedge clock);
        req = 2'b00;
        drain("t3");
        check("t3 bus_valid cycles", 64'(vcnt), 64'd4);

        // Core served normally after the timeout
        req_addr0 = A0; req_we = 2'b00; slave_wait = 0; slave_data = 64'h1234;
        gq.push_back('{1'b0, A0});
        rq.push_back('{1'b0, 64'h1234, 1'b0});
        req = 2'b01;
        @(negedge clock);
        req = 2'b00;
        drain("t3b");

        // Slave stall with payload changing mid-BUS
        req_wdata0 = W1; req_we = 2'b01; req_size0 = SIZE_BYTE;
        slave_wait = 3; slave_data = 64'h42; vcnt = 0;
        gq.push_back('{1'b0, A0});
        rq.push_back('{1'b0, 64'h42, 1'b0});
        req = 2'b01;
        @(negedge clock);
        req = 2'b00;
        req_wdata0 = 64'h0BAD_0BAD_0BAD_0BAD;
        repeat (4) begin
            check("t4 bus_wdata held", bus_wdata, W1);
            @(negedge clock);
        end
        check("t4 rvalid after 4th BUS cycle", 64'(rvalid), 64'd1);
        drain("t4");
        check("t4 bus_valid cycles", 64'(vcnt), 64'd4);

        // Reset in the second BUS cycle, then a tie goes to the core
        req_we = 2'b00; slave_wait = -1;
        gq.push_back('{1'b0, A0});
        req = 2'b01;
        @(negedge clock);
        req = 2'b00;
        @(negedge clock);
        check("t5 bus_valid before reset", 64'(bus_valid), 64'd1);
        #1 reset = 1'b1;
        #1;
        check("t5 bus_valid in reset", 64'(bus_valid), 64'd0);
        check("t5 gnt in reset", 64'(gnt), 64'd0);
        check("t5 rvalid in reset", 64'(rvalid), 64'd0);
        check("t5 busy in reset", 64'(busy), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        slave_wait = 0; slave_xor = 1'b1; slave_data = K;
        gq.push_back('{1'b0, A0});
        rq.push_back('{1'b0, E0, 1'b0});
        req = 2'b11;
        @(negedge clock);
        req = 2'b00;
        drain("t5");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/dbus_arbiter.md
Name: dbus_arbiter

Overview:
- Shares one memory-mapped peripheral data bus between two requesters: port 0 is the core MEM-stage MMIO access, port 1 is the debugger/DMA.
- Arbitrates two-way round-robin, sequences one outstanding transaction at a time and holds the bus payload stable until the slave handshakes.
- Aborts stuck transactions with a timeout.
- Returns read data and a completion pulse to the owning requester; on the core side these feed the MEM stage d_valid/d_rdata path.

Parameters:
- TIMEOUT, 16: maximum cycles bus_valid is held without bus_ready before abort (>=1).
- AW, 64: address width.
- DW, 64: data width.

Ports:
- clock input 1: rising-edge clock.
- reset input 1: asynchronous, active-high.
- req input 2: per-port request, bit0 core, bit1 dma.
- req_addr0/req_addr1 input AW each: request address.
- req_wdata0/req_wdata1 input DW each: store data.
- req_we input 2: per-port write enable.
- req_size0/req_size1 input 2 each: access size, same encoding as mem_store_type/mem_load_type (1 byte, 2 word, 3 dword).
- gnt output 2: one-cycle pulse, transaction accepted for that port.
- rvalid output 2: one-cycle pulse, transaction complete for that port.
- rdata output DW: read data, valid when any rvalid is set.
- rerr output 1: timeout flag, valid with rvalid.
- busy output 1: FSM not IDLE; core pipeline stall source.
- bus_valid output 1: transaction on bus.
- bus_addr output AW.
- bus_wdata output DW.
- bus_we output 1.
- bus_size output 2.
- bus_ready input 1: slave accepts/completes this cycle.
- bus_rdata input DW: slave read data, sampled with bus_ready.

Behaviour:
- Reset (async, takes effect immediately): state IDLE; every output 0; timer 0; last_owner=1, so the core wins the first tie.
- FSM states: IDLE, BUS, RESP.
- IDLE:
  - If req==0, remain in IDLE.
  - Otherwise select the winner. A single requester wins. If both request, the winner is ~last_owner.
  - Latch the winner's addr/wdata/we/size into bus_* registers. Set owner and last_owner to the winner. Pulse gnt[owner]. Clear the timer. Go to BUS.
  - gnt and bus_valid rise on the same edge, one cycle after req is sampled.
- BUS:
  - bus_valid=1. bus_addr/wdata/we/size are held constant.
  - If bus_ready: capture bus_rdata into rdata (writes capture it too; value is don't-care to the requester). Set rerr=0. Go to RESP.
  - Else if timer==TIMEOUT-1: set rdata=0, rerr=1, go to RESP.
  - Else timer+1.
  - bus_valid drops on the edge leaving BUS.
  - bus_ready with bus_valid=0 is ignored.
- RESP:
  - rvalid[owner]=1 for exactly one cycle; rdata/rerr stable.
  - Next state IDLE, unconditionally.
- Minimum transaction is 3 cycles: req sampled, BUS with immediate bus_ready, RESP. Back-to-back throughput is 1 transaction per 3 cycles.
- Requester rules:
  - Hold req and payload until gnt.
  - Clear req on the edge where rvalid is sampled.
  - req is sampled only in IDLE; req changes in BUS/RESP are ignored.
  - A requester dropping req after gnt does not cancel the transaction; its rvalid still pulses.
- Both requesting continuously: grants alternate core, dma, core, ...
- Timeout: the write is considered not performed, and no retry is made. The core side treats rerr as a bus-error exception source; that cp0 hookup is outside this block.
- TIMEOUT=1 means abort after a single cycle without ready.
- Timer width is $clog2(TIMEOUT+1) and the timer never wraps.
- busy is 1 in BUS and RESP, 0 in IDLE.
- At most one bit of gnt and of rvalid is ever set.

Decomposition:
- Package structures gets:
  - typedef enum logic[1:0] dbus_state_t {DBUS_IDLE, DBUS_BUS, DBUS_RESP}.
  - typedef struct packed dbus_req_t {addr, wdata, we, size}, used for the latched payload.
  - localparam for size encodings shared with the MEM stage.
- One sub-module, rr_arb2: combinational two-way round-robin picker. Inputs are req[1:0] and last_owner; outputs are the one-hot grant and the winner index. It is instantiated inside dbus_arbiter.

Test Plan:
1. Core read alone: req=01, addr0=0x1000_0008, size=3; slave ready on the 1st BUS cycle with rdata=0xDEADBEEF_CAFEF00D. Required: gnt=01 at cycle 1, bus_valid cycles 1-1, rvalid=01 at cycle 2 with that rdata, rerr=0, busy 0 at cycle 3.
2. Simultaneous requests held 4 transactions: req=11 continuously, each reissued after rvalid. Required: grant order core, dma, core, dma; bus_addr matches the owner's address each time.
3. Timeout: TIMEOUT=4, dma write with bus_ready never set. Required: bus_valid high exactly 4 cycles, then rvalid=10, rerr=1, rdata=0; next core request is served normally.
4. Slave stall: ready after 3 wait cycles while wdata0 is changed mid-BUS. Required: bus_wdata keeps the latched value; completion occurs in cycle 4 of BUS.
5. Reset asserted in the 2nd BUS cycle. Required: bus_valid, gnt, rvalid, busy go to 0 immediately; after release, a simultaneous req=11 grants the core first.
6. Requester drops req the cycle after gnt. Required: transaction still completes and rvalid pulses for that port.
